// File: rtl/dmux_n_buf_pkg.sv
// dmux_n_buf_pkg: shared Hack datapath constants for the buffered N-way dmux
package dmux_n_buf_pkg;
  localparam int WORD_W = 16;
  localparam int DMUX_WAYS_DEF = 4;
  localparam int CNT_W = 16;
endpackage

// File: rtl/dmux_n_buf_if.sv
// dmux_n_buf_if: producer-side handshake and per-way consumer bus of dmux_n_buf
interface dmux_n_buf_if #(
  parameter int WIDTH = 16,
  parameter int WAYS = 4
);
  localparam int SEL_W = $clog2(WAYS);
  logic [WIDTH-1:0] in_data;
  logic [SEL_W-1:0] in_sel;
  logic in_valid;
  logic in_ready;
  logic [WAYS*WIDTH-1:0] out_data;
  logic [WAYS-1:0] out_valid;
  logic [WAYS-1:0] out_ready;
  logic drop;
  modport master (output in_data, in_sel, in_valid, out_ready, input in_ready, out_data, out_valid, drop);
  modport slave (input in_data, in_sel, in_valid, out_ready, output in_ready, out_data, out_valid, drop);
endinterface

// File: rtl/dmux_n_buf_slot.sv
// dmux_n_buf_slot: one-entry output register; load beats drain, idle data reads zero
module dmux_n_buf_slot #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic [WIDTH-1:0] ld_data,
  input  logic out_ready,
  output logic out_valid,
  output logic [WIDTH-1:0] out_data
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data <= ld_data;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end
endmodule

// File: rtl/dmux_n_buf.sv
// dmux_n_buf: 1-to-WAYS buffered demux; DMUX_N_BUF_COUNT_EN adds per-way delivery counters
module dmux_n_buf
  import dmux_n_buf_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int WAYS = DMUX_WAYS_DEF
) (
  input  logic clk,
  input  logic reset,
  dmux_n_buf_if.slave bus
`ifdef DMUX_N_BUF_COUNT_EN
  , output logic [WAYS*CNT_W-1:0] count
`endif
);
  localparam int SEL_W = $clog2(WAYS);
  logic [WAYS-1:0] hit, load, v, drain;
  logic [WAYS*WIDTH-1:0] d;
  logic accept, drop_q;
  // An out-of-range sel hits no way, so it is always ready and loads nothing
  assign bus.in_ready = ~|(hit & v & ~bus.out_ready);
  assign accept = bus.in_valid & bus.in_ready;
  assign load = hit & {WAYS{accept}};
  assign drain = v & bus.out_ready;
  assign bus.out_valid = v;
  assign bus.out_data = d;
  assign bus.drop = drop_q;
  for (genvar k = 0; k < WAYS; k++) begin : g_way
    assign hit[k] = bus.in_sel == SEL_W'(k);
    dmux_n_buf_slot #(.WIDTH(WIDTH)) u_slot (
      .clk(clk),
      .reset(reset),
      .load(load[k]),
      .ld_data(bus.in_data),
      .out_ready(bus.out_ready[k]),
      .out_valid(v[k]),
      .out_data(d[k*WIDTH +: WIDTH])
    );
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) drop_q <= 1'b0;
    else drop_q <= accept & ~|hit;
`ifdef DMUX_N_BUF_COUNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else
      for (int i = 0; i < WAYS; i++)
        if (drain[i]) count[i*CNT_W +: CNT_W] <= count[i*CNT_W +: CNT_W] + CNT_W'(1);
`endif
endmodule
